// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: encodes decoded MIPS fields into 32-bit
// words and writes them sequentially through a registered write port.
module imem_program_loader #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       jtarget,
  input  logic              last,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StError} state_e;

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  // Final usable slot; a non-last transfer here is an overflow.
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BASE_ADDR + DEPTH - 1);
  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [31:0]       enc_word;
  logic              kind_legal;

  // busy is a registered copy of "state is LOAD", so it doubles as ready.
  assign op_ready = busy;

  // Encode the decoded fields into a MIPS word and flag illegal kinds.
  always_comb begin
    enc_word   = '0;
    kind_legal = 1'b1;
    case (op_kind)
      3'd0:    enc_word = {6'h00, rs, rt, rd, 5'd0, funct};
      3'd1:    enc_word = {6'h08, rs, rt, imm};
      3'd2:    enc_word = {6'h04, rs, rt, imm};
      3'd3:    enc_word = {6'h02, jtarget};
      3'd4:    enc_word = {6'h23, rs, rt, imm};
      3'd5:    enc_word = {6'h2B, rs, rt, imm};
      default: kind_legal = 1'b0;
    endcase
  end

  // Load FSM with registered status outputs and the write port.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      imem_wen   <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      count      <= '0;
    end else begin
      imem_wen <= 1'b0;
      case (state_q)
        StLoad: begin
          if (op_valid) begin
            if (!kind_legal) begin
              state_q  <= StError;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'd1;
            end else begin
              imem_wen   <= 1'b1;
              imem_addr  <= ptr_q;
              imem_wdata <= enc_word;
              ptr_q      <= ptr_q + PtrOne;
              count      <= count + CountOne;
              if (last) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else if (ptr_q == LastAddr) begin
                state_q  <= StError;
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= 2'd2;
              end
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR all restart on start; start in LOAD is ignored.
          if (start) begin
            state_q  <= StLoad;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
            ptr_q    <= BaseAddr;
            count    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: a full-depth and a DEPTH=4 instance share
// stimulus; each is compared every cycle against a word-count based model.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_valid = 1'b0;
  logic        last = 1'b0;
  logic [2:0]  op_kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] jtarget = '0;

  logic        rdy, wen, busy, done, error;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [1:0]  ecode;
  logic [6:0]  cnt;
  logic        rdy4, wen4, busy4, done4, error4;
  logic [5:0]  addr4;
  logic [31:0] wdata4;
  logic [1:0]  ecode4;
  logic [6:0]  cnt4;

  imem_program_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start), .op_valid(op_valid), .op_ready(rdy),
    .op_kind(op_kind), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .jtarget(jtarget), .last(last), .imem_wen(wen), .imem_addr(addr), .imem_wdata(wdata),
    .busy(busy), .done(done), .error(error), .err_code(ecode), .count(cnt)
  );

  imem_program_loader #(.ADDR_W(6), .DEPTH(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .arst_n(arst_n), .start(start), .op_valid(op_valid), .op_ready(rdy4),
    .op_kind(op_kind), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .jtarget(jtarget), .last(last), .imem_wen(wen4), .imem_addr(addr4),
    .imem_wdata(wdata4), .busy(busy4), .done(done4), .error(error4), .err_code(ecode4),
    .count(cnt4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: mode 0=idle 1=load 2=done 3=error; n = words written this sequence.
  typedef struct {
    int          mode;
    int          n;
    int          code;
    bit          wen;
    int          addr;
    logic [31:0] wdata;
  } mdl_t;

  function automatic mdl_t mzero();
    mdl_t z;
    z.mode = 0; z.n = 0; z.code = 0; z.wen = 0; z.addr = 0; z.wdata = '0;
    return z;
  endfunction

  function automatic logic [31:0] enc();
    case (op_kind)
      3'd0:    return {6'h00, rs, rt, rd, 5'd0, funct};
      3'd1:    return {6'h08, rs, rt, imm};
      3'd2:    return {6'h04, rs, rt, imm};
      3'd3:    return {6'h02, jtarget};
      3'd4:    return {6'h23, rs, rt, imm};
      default: return {6'h2B, rs, rt, imm};
    endcase
  endfunction

  function automatic mdl_t step(mdl_t c, int depth);
    mdl_t n = c;
    n.wen = 0;
    if (c.mode != 1) begin
      if (start) begin
        n.mode = 1; n.n = 0; n.code = 0;
      end
    end else if (op_valid) begin
      if (op_kind > 3'd5) begin
        n.mode = 3; n.code = 1;
      end else begin
        n.wen = 1;
        n.addr = c.n % 64;
        n.wdata = enc();
        n.n = c.n + 1;
        if (last) n.mode = 2;
        else if (n.n == depth) begin
          n.mode = 3; n.code = 2;
        end
      end
    end
    return n;
  endfunction

  mdl_t m, m4;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m  <= mzero();
      m4 <= mzero();
    end else begin
      m  <= step(m, 64);
      m4 <= step(m4, 4);
    end
  end

  task automatic cmp(string t, mdl_t e, logic a_rdy, logic a_wen, logic [5:0] a_addr,
                     logic [31:0] a_wd, logic a_busy, logic a_done, logic a_err,
                     logic [1:0] a_code, logic [6:0] a_cnt);
    chk({t, " op_ready"}, a_rdy, e.mode == 1);
    chk({t, " imem_wen"}, a_wen, e.wen);
    chk({t, " imem_addr"}, a_addr, e.addr);
    chk({t, " imem_wdata"}, a_wd, e.wdata);
    chk({t, " busy"}, a_busy, e.mode == 1);
    chk({t, " done"}, a_done, e.mode == 2);
    chk({t, " error"}, a_err, e.mode == 3);
    chk({t, " err_code"}, a_code, e.code);
    chk({t, " count"}, a_cnt, e.n);
  endtask

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t wlog[$];
  wr_t wlog4[$];

  // Per-cycle comparison and write logging, away from the active edge.
  always @(negedge clk) begin
    wr_t w;
    cmp("dut64", m, rdy, wen, addr, wdata, busy, done, error, ecode, cnt);
    cmp("dut4", m4, rdy4, wen4, addr4, wdata4, busy4, done4, error4, ecode4, cnt4);
    if (wen) begin
      w.addr = int'(addr); w.data = wdata; w.cyc = cyc;
      wlog.push_back(w);
    end
    if (wen4) begin
      w.addr = int'(addr4); w.data = wdata4; w.cyc = cyc;
      wlog4.push_back(w);
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic xfer(logic [2:0] k, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                      logic [5:0] f, logic [15:0] i, logic [25:0] j, logic l);
    op_kind = k; rs = s; rt = t; rd = d; funct = f; imm = i; jtarget = j; last = l;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
  endtask

  task automatic chk_wr(string n, int i, int a, logic [31:0] d);
    if (wlog.size() <= i) chk({n, " nwrites"}, wlog.size(), i + 1);
    else begin
      chk({n, " addr"}, wlog[i].addr, a);
      chk({n, " data"}, wlog[i].data, d);
    end
  endtask

  task automatic chk_wr4(string n, int i, int a, logic [31:0] d);
    if (wlog4.size() <= i) chk({n, " nwrites"}, wlog4.size(), i + 1);
    else begin
      chk({n, " addr"}, wlog4[i].addr, a);
      chk({n, " data"}, wlog4[i].data, d);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wen", wen, 1'b0);
    chk("reset op_ready", rdy, 1'b0);
    chk("reset count", cnt, 7'd0);
    chk("reset wdata", wdata, 32'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    // Basic program: R, ADDI, J(last)
    wlog.delete();
    do_start();
    xfer(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
    xfer(3'd1, 5'd0, 5'd1, 5'd0, 6'h0, 16'd5, 26'h0, 1'b0);
    xfer(3'd3, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1);
    chk("prog1 done", done, 1'b1);
    chk("prog1 count", cnt, 7'd3);
    settle();
    chk("prog1 nwrites", wlog.size(), 3);
    chk_wr("prog1 w0", 0, 0, 32'h00221820);
    chk_wr("prog1 w1", 1, 1, 32'h20010005);
    chk_wr("prog1 w2", 2, 2, 32'h08000010);

    // LW/SW back-to-back, then BEQ(last)
    wlog.delete();
    do_start();
    xfer(3'd4, 5'd29, 5'd8, 5'd0, 6'h0, 16'hFFFC, 26'h0, 1'b0);
    xfer(3'd5, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0);
    xfer(3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b1);
    settle();
    chk_wr("lwsw w0", 0, 0, 32'h8FA8FFFC);
    chk_wr("lwsw w1", 1, 1, 32'hAFA80004);
    chk_wr("lwsw w2", 2, 2, 32'h1022FFFF);
    if (wlog.size() >= 2) chk("lwsw consecutive", wlog[1].cyc - wlog[0].cyc, 1);

    // Illegal kind after one legal word
    wlog.delete();
    do_start();
    xfer(3'd1, 5'd0, 5'd1, 5'd0, 6'h0, 16'd7, 26'h0, 1'b0);
    xfer(3'd7, 5'd3, 5'd4, 5'd5, 6'h0, 16'd1, 26'h0, 1'b0);
    chk("illegal error", error, 1'b1);
    chk("illegal err_code", ecode, 2'd1);
    chk("illegal count", cnt, 7'd1);
    settle();
    chk("illegal nwrites", wlog.size(), 1);
    do_start();
    chk("restart busy", busy, 1'b1);
    chk("restart count", cnt, 7'd0);
    chk("restart err_code", ecode, 2'd0);

    // Overflow on the DEPTH=4 instance, then the same with last on slot 3
    do_reset();
    wlog4.delete();
    do_start();
    for (int k = 0; k < 4; k++) xfer(3'd1, 5'd0, 5'd1, 5'd0, 6'h0, 16'(k), 26'h0, 1'b0);
    chk("ovf error", error4, 1'b1);
    chk("ovf err_code", ecode4, 2'd2);
    settle();
    chk("ovf nwrites", wlog4.size(), 4);
    chk_wr4("ovf w0", 0, 0, 32'h20010000);
    chk_wr4("ovf w3", 3, 3, 32'h20010003);
    wlog4.delete();
    do_start();
    for (int k = 0; k < 4; k++) xfer(3'd1, 5'd0, 5'd1, 5'd0, 6'h0, 16'(k), 26'h0, k == 3);
    chk("full done", done4, 1'b1);
    chk("full err_code", ecode4, 2'd0);
    chk("full count", cnt4, 7'd4);

    // Reset right after a transfer suppresses the pending write
    do_start();
    wlog.delete();
    op_kind = 3'd1; rs = 5'd2; rt = 5'd3; imm = 16'h1234; last = 1'b0;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    arst_n = 1'b0;
    settle();
    chk("abort nwrites", wlog.size(), 0);
    chk("abort wen", wen, 1'b0);
    chk("abort addr", addr, 6'd0);
    chk("abort count", cnt, 7'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    do_start();
    xfer(3'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b0);
    settle();
    chk_wr("after abort", 0, 0, 32'h20431234);

    // op_valid held through DONE; start inside LOAD is ignored
    wlog.delete();
    op_kind = 3'd0; rs = 5'd4; rt = 5'd5; rd = 5'd6; funct = 6'h22; last = 1'b1;
    op_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    op_valid = 1'b0; last = 1'b0;
    chk("held op_ready", rdy, 1'b0);
    settle();
    chk("held nwrites", wlog.size(), 1);
    wlog.delete();
    do_start();
    xfer(3'd1, 5'd0, 5'd1, 5'd0, 6'h0, 16'd9, 26'h0, 1'b0);
    do_start();
    xfer(3'd1, 5'd0, 5'd1, 5'd0, 6'h0, 16'd10, 26'h0, 1'b1);
    settle();
    chk_wr("ignored start", 1, 1, 32'h2001000A);
    chk("ignored start count", cnt, 7'd2);

    // Randomized traffic, including illegal kinds, restarts and resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!arst_n) arst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) arst_n = 1'b0;
      start    = ($urandom_range(0, 11) == 0);
      op_valid = ($urandom_range(0, 9) < 6);
      op_kind  = ($urandom_range(0, 99) < 4) ? 3'(6 + $urandom_range(0, 1))
                                             : 3'($urandom_range(0, 5));
      rs       = 5'($urandom);
      rt       = 5'($urandom);
      rd       = 5'($urandom);
      funct    = 6'($urandom);
      imm      = 16'($urandom);
      jtarget  = 26'($urandom);
      last     = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; op_valid = 1'b0; arst_n = 1'b1;
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
